learnt_clause_collect: RTL and testbench
========================================

// Module: learnt_clause_collect
// PURPOSE
//  Downstream consumer of the per-variable state array in the Sat Engine. After conflict analysis, snapshots
//  every variable's learnt_lit/var_lvl, scans them one variable per cycle, and emits one learnt clause
//  (2-bit-per-var bitmap), its length, the backtrack level and the current-level literal count.
//  Result goes to the backtrack controller / clause writer over a valid/ready handshake.
// PARAMETERS
//  NUM_VARS     8   variables per bin (scan length)
//  WIDTH_LVL    16  decision-level width
//  WIDTH_C_LEN  4   clause-length counter width; must hold NUM_VARS
// PORTS
//  clk             in   1                    clock, rising edge
//  rst             in   1                    asynchronous reset, active-high
//  start_i         in   1                    pulse: analysis finished, collect clause
//  cur_lvl_i       in   WIDTH_LVL            current decision level, sampled with start_i
//  learnt_lits_i   in   2*NUM_VARS           learnt_lit of var k at [2k+1:2k]
//  var_lvls_i      in   WIDTH_LVL*NUM_VARS   var_lvl of var k at [W*(k+1)-1:W*k]
//  busy_o          out  1                    high in SCAN and OUT
//  learnt_valid_o  out  1                    result valid; held until accepted
//  learnt_ready_i  in   1                    consumer accepts when valid&ready
//  clause_o        out  2*NUM_VARS           learnt clause bitmap (00 = var absent)
//  clause_len_o    out  WIDTH_C_LEN          number of literals
//  bkt_lvl_o       out  WIDTH_LVL            max level over literals with lvl != cur_lvl; 0 if none
//  cur_lvl_cnt_o   out  WIDTH_C_LEN          literals with lvl == cur_lvl (1 = valid UIP clause)
//  err_o           out  1                    sticky for this clause: a 2'b11 literal was seen
// BEHAVIOUR
//  Reset: all outputs and registers 0; FSM = IDLE.
//  FSM IDLE -> SCAN -> OUT -> IDLE.
//   IDLE: start_i=1 -> snapshot learnt_lits_i, var_lvls_i, cur_lvl_i into registers; clear len, bkt, cnt, err,
//     clause; idx<=0; go SCAN. Input changes after the start cycle are ignored.
//   SCAN: one var per cycle, idx 0..NUM_VARS-1, using the snapshot only.
//     lit 01/10: clause[idx]<=lit; len+1; if lvl==cur_lvl then cnt+1, else bkt<=max(bkt,lvl).
//     lit 00: no effect. lit 11: treated as absent, err<=1.
//     idx==NUM_VARS-1 -> go OUT next cycle.
//   OUT: learnt_valid_o=1, outputs stable. valid&ready -> IDLE, valid drops next cycle; outputs keep
//     their values until the next start.
//  Latency: start at cycle T -> learnt_valid_o high at cycle T+NUM_VARS+1. With ready held high:
//   next start is accepted one cycle after the handshake.
//  start_i in SCAN or OUT: ignored; it is not queued.
//  Empty clause (len=0): still emitted with bkt=0, cnt=0; consumer treats it as UNSAT.
//  Level comparison is unsigned. len/cnt never overflow because NUM_VARS fits in WIDTH_C_LEN.
//  Reset mid-SCAN/OUT: immediate return to IDLE; valid drops asynchronously; partial result discarded.
// STRUCTURE
//  Shared package sat_pkg: lit encoding constants LIT_NONE=2'b00, LIT_POS=2'b01, LIT_NEG=2'b10,
//   LIT_BAD=2'b11; FSM state enum; WIDTH_LVL/WIDTH_C_LEN defaults.
//  Sub-module lit_lvl_accum: the per-cycle accumulator (len/cnt/bkt/err) fed by one {lit,lvl} pair.
//   Top level holds the FSM, snapshot registers, index mux and clause bitmap writes.
// TESTING
//  1 NUM_VARS=8, cur=5, lits v0=01@5, v3=10@2, v6=01@4 -> clause=0x1081, len=3, bkt=4, cnt=1, err=0,
//    valid at T+9.
//  2 All lits 00 -> len=0, bkt=0, cnt=0, valid asserted once; ready=1 -> back to IDLE.
//  3 ready held low 10 cycles after valid -> outputs stable; start_i pulses in OUT ignored;
//    ready=1 -> single handshake.
//  4 v2=11@3, v5=01@7, cur=7 -> err=1, len=1, cnt=1, bkt=0, clause bit pair 2 = 00.
//  5 learnt_lits_i changed to all-01 on cycle T+1 -> result matches the snapshot taken at T.
//  6 rst asserted at T+4 mid-scan -> valid=0 immediately, busy=0; a new start after release
//    produces a clean, correct clause.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared Sat Engine definitions: literal encoding, collector FSM states and default widths.
package sat_pkg;

  localparam logic [1:0] LIT_NONE = 2'b00;
  localparam logic [1:0] LIT_POS  = 2'b01;
  localparam logic [1:0] LIT_NEG  = 2'b10;
  localparam logic [1:0] LIT_BAD  = 2'b11;

  localparam int WIDTH_LVL_DEF   = 16;
  localparam int WIDTH_C_LEN_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2
  } collect_state_e;

  // A literal belongs in the clause only when it carries a polarity.
  function automatic logic lit_present(input logic [1:0] lit);
    return (lit == LIT_POS) || (lit == LIT_NEG);
  endfunction

endpackage

// File: rtl/learnt_clause_collect_lit_lvl_accum.sv
// Per-cycle accumulator for one {lit, lvl} pair: clause length, current-level count,
// backtrack level (max of lower levels) and the sticky bad-literal flag.
module lit_lvl_accum
  import sat_pkg::*;
#(
  parameter int WIDTH_LVL   = WIDTH_LVL_DEF,
  parameter int WIDTH_C_LEN = WIDTH_C_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   en_i,
  input  logic [1:0]             lit_i,
  input  logic [WIDTH_LVL-1:0]   lvl_i,
  input  logic [WIDTH_LVL-1:0]   cur_lvl_i,
  output logic [WIDTH_C_LEN-1:0] len_o,
  output logic [WIDTH_C_LEN-1:0] cnt_o,
  output logic [WIDTH_LVL-1:0]   bkt_o,
  output logic                   err_o
);

  logic [WIDTH_C_LEN-1:0] len_q;
  logic [WIDTH_C_LEN-1:0] cnt_q;
  logic [WIDTH_LVL-1:0]   bkt_q;
  logic                   err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0;
      cnt_q <= '0;
      bkt_q <= '0;
      err_q <= 1'b0;
    end else if (clear_i) begin
      len_q <= '0;
      cnt_q <= '0;
      bkt_q <= '0;
      err_q <= 1'b0;
    end else if (en_i) begin
      if (lit_present(lit_i)) begin
        len_q <= len_q + 1'b1;
        if (lvl_i == cur_lvl_i) begin
          cnt_q <= cnt_q + 1'b1;
        end else if (lvl_i > bkt_q) begin
          bkt_q <= lvl_i;
        end
      end else if (lit_i == LIT_BAD) begin
        err_q <= 1'b1;
      end
    end
  end

  assign len_o = len_q;
  assign cnt_o = cnt_q;
  assign bkt_o = bkt_q;
  assign err_o = err_q;

endmodule

// File: rtl/learnt_clause_collect.sv
// Snapshots the per-variable learnt_lit/var_lvl array on start, scans one variable per cycle and
// presents the learnt clause with its length, backtrack level and current-level count over valid/ready.
module learnt_clause_collect
  import sat_pkg::*;
#(
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_LVL   = WIDTH_LVL_DEF,
  parameter int WIDTH_C_LEN = WIDTH_C_LEN_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [WIDTH_LVL-1:0]          cur_lvl_i,
  input  logic [2*NUM_VARS-1:0]         learnt_lits_i,
  input  logic [WIDTH_LVL*NUM_VARS-1:0] var_lvls_i,
  output logic                          busy_o,
  output logic                          learnt_valid_o,
  input  logic                          learnt_ready_i,
  output logic [2*NUM_VARS-1:0]         clause_o,
  output logic [WIDTH_C_LEN-1:0]        clause_len_o,
  output logic [WIDTH_LVL-1:0]          bkt_lvl_o,
  output logic [WIDTH_C_LEN-1:0]        cur_lvl_cnt_o,
  output logic                          err_o
);

  localparam int IDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);

  collect_state_e              state_q;
  logic [IDX_W-1:0]            idx_q;
  logic [2*NUM_VARS-1:0]       lits_q;
  logic [WIDTH_LVL*NUM_VARS-1:0] lvls_q;
  logic [WIDTH_LVL-1:0]        cur_lvl_q;
  logic [2*NUM_VARS-1:0]       clause_q;
  logic [2*NUM_VARS-1:0]       clause_d;
  logic                        valid_q;
  logic                        busy_q;

  logic [1:0]                  scan_lit;
  logic [WIDTH_LVL-1:0]        scan_lvl;
  logic                        take_start;
  logic                        scan_en;

  assign take_start = (state_q == ST_IDLE) && start_i;
  assign scan_en    = (state_q == ST_SCAN);
  assign scan_lit   = lits_q[{idx_q, 1'b0} +: 2];
  assign scan_lvl   = lvls_q[idx_q*WIDTH_LVL +: WIDTH_LVL];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    clause_d = clause_q;
    if (lit_present(scan_lit)) begin
      clause_d[{idx_q, 1'b0} +: 2] = scan_lit;
    end
  end

  // NOTE: the snapshot array is reset as well, so the scan never reads undefined data after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      lits_q    <= '0;
      lvls_q    <= '0;
      cur_lvl_q <= '0;
      clause_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            lits_q    <= learnt_lits_i;
            lvls_q    <= var_lvls_i;
            cur_lvl_q <= cur_lvl_i;
            clause_q  <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          clause_q <= clause_d;
          idx_q    <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            valid_q <= 1'b1;
            state_q <= ST_OUT;
          end
        end
        ST_OUT: begin
          // Result stays on the outputs after the handshake until the next start clears it.
          if (learnt_ready_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  lit_lvl_accum #(
    .WIDTH_LVL  (WIDTH_LVL),
    .WIDTH_C_LEN(WIDTH_C_LEN)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (take_start),
    .en_i     (scan_en),
    .lit_i    (scan_lit),
    .lvl_i    (scan_lvl),
    .cur_lvl_i(cur_lvl_q),
    .len_o    (clause_len_o),
    .cnt_o    (cur_lvl_cnt_o),
    .bkt_o    (bkt_lvl_o),
    .err_o    (err_o)
  );

  assign clause_o       = clause_q;
  assign learnt_valid_o = valid_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_learnt_clause_collect.sv
// Directed bench for learnt_clause_collect: vector table plus hand-written multi-cycle sequences.
module tb_learnt_clause_collect;

  localparam int NV = 8;
  localparam int WL = 16;
  localparam int WC = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_i = 1'b0;
  logic [WL-1:0]   cur_lvl_i = '0;
  logic [2*NV-1:0] learnt_lits_i = '0;
  logic [WL*NV-1:0] var_lvls_i = '0;
  logic            busy_o;
  logic            learnt_valid_o;
  logic            learnt_ready_i = 1'b0;
  logic [2*NV-1:0] clause_o;
  logic [WC-1:0]   clause_len_o;
  logic [WL-1:0]   bkt_lvl_o;
  logic [WC-1:0]   cur_lvl_cnt_o;
  logic            err_o;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  learnt_clause_collect #(.NUM_VARS(NV), .WIDTH_LVL(WL), .WIDTH_C_LEN(WC)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .cur_lvl_i     (cur_lvl_i),
    .learnt_lits_i (learnt_lits_i),
    .var_lvls_i    (var_lvls_i),
    .busy_o        (busy_o),
    .learnt_valid_o(learnt_valid_o),
    .learnt_ready_i(learnt_ready_i),
    .clause_o      (clause_o),
    .clause_len_o  (clause_len_o),
    .bkt_lvl_o     (bkt_lvl_o),
    .cur_lvl_cnt_o (cur_lvl_cnt_o),
    .err_o         (err_o)
  );

  typedef struct {
    string            name;
    logic [2*NV-1:0]  lits;
    logic [WL*NV-1:0] lvls;
    logic [WL-1:0]    cur;
    logic [2*NV-1:0]  exp_clause;
    logic [WC-1:0]    exp_len;
    logic [WL-1:0]    exp_bkt;
    logic [WC-1:0]    exp_cnt;
    logic             exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_result(input vec_t v);
    check({v.name, ".clause"}, 64'(clause_o), 64'(v.exp_clause));
    check({v.name, ".len"},    64'(clause_len_o), 64'(v.exp_len));
    check({v.name, ".bkt"},    64'(bkt_lvl_o), 64'(v.exp_bkt));
    check({v.name, ".cnt"},    64'(cur_lvl_cnt_o), 64'(v.exp_cnt));
    check({v.name, ".err"},    64'(err_o), 64'(v.exp_err));
  endtask

  // Pulse start on a negedge and wait (bounded) for valid; returns with valid high, ready low.
  task automatic start_and_wait(input vec_t v);
    int cyc;
    learnt_lits_i = v.lits;
    var_lvls_i    = v.lvls;
    cur_lvl_i     = v.cur;
    start_i       = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    check({v.name, ".busy_scan"}, 64'(busy_o), 64'd1);
    while (!learnt_valid_o && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({v.name, ".latency"}, 64'(cyc), 64'd9);
    check({v.name, ".busy_out"}, 64'(busy_o), 64'd1);
  endtask

  task automatic handshake(input string name);
    learnt_ready_i = 1'b1;
    @(negedge clk);
    learnt_ready_i = 1'b0;
    check({name, ".valid_drop"}, 64'(learnt_valid_o), 64'd0);
    check({name, ".busy_drop"},  64'(busy_o), 64'd0);
  endtask

  initial begin
    bit seen_valid;

    vecs[0] = '{"v1_basic", 16'h1081,
                {16'd0, 16'd4, 16'd0, 16'd0, 16'd2, 16'd0, 16'd0, 16'd5}, 16'd5,
                16'h1081, 4'd3, 16'd4, 4'd1, 1'b0};
    vecs[1] = '{"v2_empty", 16'h0000, {8{16'd6}}, 16'd5,
                16'h0000, 4'd0, 16'd0, 4'd0, 1'b0};
    vecs[2] = '{"v4_bad", 16'h0430,
                {16'd0, 16'd0, 16'd7, 16'd0, 16'd0, 16'd3, 16'd0, 16'd0}, 16'd7,
                16'h0400, 4'd1, 16'd0, 4'd1, 1'b1};
    vecs[3] = '{"all_cur", 16'hAAAA, {8{16'd3}}, 16'd3,
                16'hAAAA, 4'd8, 16'd0, 4'd8, 1'b0};
    vecs[4] = '{"unsigned", 16'h8104,
                {16'h8000, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'hFFFF, 16'd0}, 16'd1,
                16'h8104, 4'd3, 16'hFFFF, 4'd1, 1'b0};
    vecs[5] = '{"all_bad", 16'hFFFF, {8{16'd9}}, 16'd2,
                16'h0000, 4'd0, 16'd0, 4'd0, 1'b1};

    repeat (2) @(negedge clk);
    check("reset.valid",  64'(learnt_valid_o), 64'd0);
    check("reset.busy",   64'(busy_o), 64'd0);
    check("reset.clause", 64'(clause_o), 64'd0);
    check("reset.len",    64'(clause_len_o), 64'd0);
    check("reset.bkt",    64'(bkt_lvl_o), 64'd0);
    check("reset.cnt",    64'(cur_lvl_cnt_o), 64'd0);
    check("reset.err",    64'(err_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors; all_bad is followed by the table wrap to show err clears on start.
    for (int i = 0; i < 6; i++) begin
      start_and_wait(vecs[i]);
      check_result(vecs[i]);
      handshake(vecs[i].name);
      check({vecs[i].name, ".hold_after_hs"}, 64'(clause_o), 64'(vecs[i].exp_clause));
    end
    start_and_wait(vecs[0]);
    check_result(vecs[0]);
    handshake("err_clear");

    // Ready held low with ignored start pulses in OUT, then a single handshake.
    start_and_wait(vecs[0]);
    for (int c = 0; c < 10; c++) begin
      if (c % 3 == 0) begin
        learnt_lits_i = 16'hFFFF;
        start_i       = 1'b1;
      end
      @(negedge clk);
      start_i = 1'b0;
      check("stall.valid", 64'(learnt_valid_o), 64'd1);
    end
    check_result(vecs[0]);
    handshake("stall");
    seen_valid = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (learnt_valid_o || busy_o) seen_valid = 1'b1;
    end
    check("stall.no_queued_start", 64'(seen_valid), 64'd0);

    // Inputs changed the cycle after start: result reflects the snapshot.
    learnt_lits_i = vecs[0].lits;
    var_lvls_i    = vecs[0].lvls;
    cur_lvl_i     = vecs[0].cur;
    start_i       = 1'b1;
    @(negedge clk);
    start_i       = 1'b0;
    learnt_lits_i = 16'h5555;
    var_lvls_i    = {8{16'd1}};
    cur_lvl_i     = 16'd1;
    begin
      int cyc;
      cyc = 1;
      while (!learnt_valid_o && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check("snap.latency", 64'(cyc), 64'd9);
    end
    check_result(vecs[0]);
    handshake("snap");

    // Reset in the middle of a scan, then a clean collection.
    learnt_lits_i = vecs[2].lits;
    var_lvls_i    = vecs[2].lvls;
    cur_lvl_i     = vecs[2].cur;
    start_i       = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst.busy_before", 64'(busy_o), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst.valid", 64'(learnt_valid_o), 64'd0);
    check("midrst.busy",  64'(busy_o), 64'd0);
    check("midrst.len",   64'(clause_len_o), 64'd0);
    check("midrst.err",   64'(err_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_and_wait(vecs[0]);
    check_result(vecs[0]);
    handshake("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
